store_queue: RTL and testbench

- In-order store queue that receives AGU store-pipe enqueues and buffers them as speculative entries.
- ROB commit pulses mark the oldest speculative entries committed. Committed entries drain one at a time to the data-memory write port.
- Provides a registered load/store address-conflict check and a full indication for back-pressure.

---
 rtl/store_queue.sv | 131 +++++++++++++
 tb/tb_store_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue.sv
// In-order store queue: speculative enqueue, ROB commit, one-at-a-time drain to memory, 1-cycle conflict probe.
// Drain payload is combinational from head and held until mem_ack_i; enqueue_full_o back-pressures the AGU pipe.
module store_queue #(
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input  logic        cpu_clock_i,
  input  logic        cpu_resetn_i,
  input  logic        flush_i,
  input  logic        enqueue_en_i,
  input  logic [29:0] enqueue_address_i,
  input  logic [31:0] enqueue_data_i,
  input  logic [3:0]  enqueue_bm_i,
  input  logic        enqueue_io_i,
  input  logic [4:0]  enqueue_rob_i,
  output logic        enqueue_full_o,
  input  logic        commit_store_i,
  input  logic        conflict_vld_i,
  input  logic [29:0] conflict_address_i,
  input  logic [3:0]  conflict_bm_i,
  output logic        conflict_o,
  output logic        mem_req_o,
  output logic [29:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_bm_o,
  output logic        mem_io_o,
  input  logic        mem_ack_i,
  output logic        sq_empty_o
);

  localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];
  localparam logic [PW:0] PTR_ONE   = {{PW{1'b0}}, 1'b1};

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PW:0] head_q;
  logic [PW:0] cmt_q;
  logic [PW:0] tail_q;
  logic        conflict_q;

  logic [29:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [3:0]  bm_q   [DEPTH];
  logic        io_q   [DEPTH];
  logic [4:0]  rob_q  [DEPTH];

  logic [PW:0]      occupancy;
  logic [PW:0]      spec_cnt;
  logic             full;
  logic             enq_fire;
  logic             cmt_fire;
  logic             pop;
  logic [PW-1:0]    head_idx;
  logic [PW-1:0]    tail_idx;
  logic [DEPTH-1:0] entry_vld;
  logic [DEPTH-1:0] entry_hit;

  assign head_idx  = head_q[PW-1:0];
  assign tail_idx  = tail_q[PW-1:0];
  assign occupancy = tail_q - head_q;
  assign spec_cnt  = tail_q - cmt_q;
  assign full      = (occupancy == DEPTH_CNT);

  assign enqueue_full_o = full;
  assign sq_empty_o     = (head_q == tail_q);

  assign enq_fire = enqueue_en_i & ~full & ~flush_i;
  assign cmt_fire = commit_store_i & (cmt_q != tail_q);

  assign mem_req_o  = (head_q != cmt_q);
  assign mem_addr_o = addr_q[head_idx];
  assign mem_data_o = data_q[head_idx];
  assign mem_bm_o   = bm_q[head_idx];
  assign mem_io_o   = io_q[head_idx];
  assign pop        = mem_req_o & mem_ack_i;

  assign conflict_o = conflict_q;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    entry_vld = '0;
    entry_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_vld[i] = ({1'b0, PW'(i) - head_idx} < occupancy);
      entry_hit[i] = entry_vld[i]
                   & (addr_q[i] == conflict_address_i)
                   & (|(bm_q[i] & conflict_bm_i));
    end
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      head_q     <= '0;
      cmt_q      <= '0;
      tail_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (pop) begin
        head_q <= head_q + PTR_ONE;
      end
      if (cmt_fire) begin
        cmt_q <= cmt_q + PTR_ONE;
      end
      // Flush keeps committed entries, including one committed this same cycle.
      if (flush_i) begin
        tail_q <= cmt_q + {{PW{1'b0}}, cmt_fire};
      end else if (enq_fire) begin
        tail_q <= tail_q + PTR_ONE;
      end
      conflict_q <= conflict_vld_i & (|entry_hit);
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (enq_fire) begin
      addr_q[tail_idx] <= enqueue_address_i;
      data_q[tail_idx] <= enqueue_data_i;
      bm_q[tail_idx]   <= enqueue_bm_i;
      io_q[tail_idx]   <= enqueue_io_i;
      rob_q[tail_idx]  <= enqueue_rob_i;
    end
  end

  a_commit_has_store: assert property (
    @(posedge cpu_clock_i) disable iff (!cpu_resetn_i)
    commit_store_i |-> (cmt_q != tail_q));

  a_pointer_order: assert property (
    @(posedge cpu_clock_i) disable iff (!cpu_resetn_i)
    (occupancy <= DEPTH_CNT) && (spec_cnt <= occupancy));

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: inputs change on the falling edge, outputs checked there too.
module tb_store_queue;

  logic        cpu_clock_i = 1'b0;
  logic        cpu_resetn_i;
  logic        flush_i;
  logic        enqueue_en_i;
  logic [29:0] enqueue_address_i;
  logic [31:0] enqueue_data_i;
  logic [3:0]  enqueue_bm_i;
  logic        enqueue_io_i;
  logic [4:0]  enqueue_rob_i;
  logic        enqueue_full_o;
  logic        commit_store_i;
  logic        conflict_vld_i;
  logic [29:0] conflict_address_i;
  logic [3:0]  conflict_bm_i;
  logic        conflict_o;
  logic        mem_req_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_bm_o;
  logic        mem_io_o;
  logic        mem_ack_i;
  logic        sq_empty_o;

  int errors = 0;
  int checks = 0;

  store_queue #(.DEPTH(8), .PW(3)) dut (
    .cpu_clock_i        (cpu_clock_i),
    .cpu_resetn_i       (cpu_resetn_i),
    .flush_i            (flush_i),
    .enqueue_en_i       (enqueue_en_i),
    .enqueue_address_i  (enqueue_address_i),
    .enqueue_data_i     (enqueue_data_i),
    .enqueue_bm_i       (enqueue_bm_i),
    .enqueue_io_i       (enqueue_io_i),
    .enqueue_rob_i      (enqueue_rob_i),
    .enqueue_full_o     (enqueue_full_o),
    .commit_store_i     (commit_store_i),
    .conflict_vld_i     (conflict_vld_i),
    .conflict_address_i (conflict_address_i),
    .conflict_bm_i      (conflict_bm_i),
    .conflict_o         (conflict_o),
    .mem_req_o          (mem_req_o),
    .mem_addr_o         (mem_addr_o),
    .mem_data_o         (mem_data_o),
    .mem_bm_o           (mem_bm_o),
    .mem_io_o           (mem_io_o),
    .mem_ack_i          (mem_ack_i),
    .sq_empty_o         (sq_empty_o)
  );

  always #5 cpu_clock_i = ~cpu_clock_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge cpu_clock_i);
  endtask

  task automatic idle_inputs();
    flush_i            = 1'b0;
    enqueue_en_i       = 1'b0;
    enqueue_address_i  = '0;
    enqueue_data_i     = '0;
    enqueue_bm_i       = '0;
    enqueue_io_i       = 1'b0;
    enqueue_rob_i      = '0;
    commit_store_i     = 1'b0;
    conflict_vld_i     = 1'b0;
    conflict_address_i = '0;
    conflict_bm_i      = '0;
    mem_ack_i          = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    cpu_resetn_i = 1'b0;
    tick();
    tick();
    cpu_resetn_i = 1'b1;
    tick();
  endtask

  task automatic enq(input logic [29:0] a, input logic [31:0] d, input logic [3:0] bm);
    enqueue_en_i      = 1'b1;
    enqueue_address_i = a;
    enqueue_data_i    = d;
    enqueue_bm_i      = bm;
    enqueue_io_i      = a[0];
    enqueue_rob_i     = a[4:0];
    tick();
    enqueue_en_i = 1'b0;
  endtask

  task automatic commit_n(input int n);
    for (int k = 0; k < n; k++) begin
      commit_store_i = 1'b1;
      tick();
    end
    commit_store_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sq_empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", sq_empty_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
    checks++; if (enqueue_full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", enqueue_full_o); end
    checks++; if (conflict_o !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b want 0", conflict_o); end
  endtask

  task automatic test_basic_flow();
    do_reset();
    enq(30'h100, 32'hA000_0100, 4'b1111);
    enq(30'h101, 32'hA000_0101, 4'b1111);
    enq(30'h102, 32'hA000_0102, 4'b1111);
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL basic_uncommitted_req: got %b want 0", mem_req_o); end
    commit_n(2);
    mem_ack_i = 1'b1;
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 30'h100 || mem_data_o !== 32'hA000_0100)
      begin errors++; $display("FAIL basic_drain0: got req=%b addr=%h data=%h want 1 100 a0000100", mem_req_o, mem_addr_o, mem_data_o); end
    checks++; if (mem_bm_o !== 4'b1111 || mem_io_o !== 1'b0)
      begin errors++; $display("FAIL basic_drain0_bm_io: got bm=%b io=%b want 1111 0", mem_bm_o, mem_io_o); end
    tick();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 30'h101 || mem_data_o !== 32'hA000_0101)
      begin errors++; $display("FAIL basic_drain1: got req=%b addr=%h data=%h want 1 101 a0000101", mem_req_o, mem_addr_o, mem_data_o); end
    checks++; if (mem_io_o !== 1'b1) begin errors++; $display("FAIL basic_drain1_io: got %b want 1", mem_io_o); end
    tick();
    mem_ack_i = 1'b0;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL basic_req_done: got %b want 0", mem_req_o); end
    checks++; if (sq_empty_o !== 1'b0) begin errors++; $display("FAIL basic_not_empty: got %b want 0", sq_empty_o); end
  endtask

  task automatic test_full_backpressure();
    logic [29:0] exp_a;
    logic [31:0] exp_d;
    do_reset();
    for (int k = 0; k < 8; k++) enq(30'h200 + 30'(k), 32'h1000 + 32'(k), 4'b1111);
    checks++; if (enqueue_full_o !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", enqueue_full_o); end
    checks++; if (dut.tail_q !== 4'b1000) begin errors++; $display("FAIL full_tail_wrap: got %b want 1000", dut.tail_q); end
    // Hold the 9th store while committing one.
    enqueue_en_i      = 1'b1;
    enqueue_address_i = 30'h2FF;
    enqueue_data_i    = 32'h99;
    enqueue_bm_i      = 4'b1111;
    commit_store_i    = 1'b1;
    tick();
    commit_store_i = 1'b0;
    checks++; if (dut.tail_q !== 4'b1000 || enqueue_full_o !== 1'b1)
      begin errors++; $display("FAIL full_reject: got tail=%b full=%b want 1000 1", dut.tail_q, enqueue_full_o); end
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 30'h200)
      begin errors++; $display("FAIL full_req: got req=%b addr=%h want 1 200", mem_req_o, mem_addr_o); end
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    checks++; if (dut.tail_q !== 4'b1000 || enqueue_full_o !== 1'b0)
      begin errors++; $display("FAIL full_ack_same_cycle: got tail=%b full=%b want 1000 0", dut.tail_q, enqueue_full_o); end
    tick();
    enqueue_en_i = 1'b0;
    checks++; if (dut.tail_q !== 4'b1001 || enqueue_full_o !== 1'b1)
      begin errors++; $display("FAIL full_accept_next: got tail=%b full=%b want 1001 1", dut.tail_q, enqueue_full_o); end
    commit_n(8);
    mem_ack_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_a = (k < 7) ? 30'h201 + 30'(k) : 30'h2FF;
      exp_d = (k < 7) ? 32'h1001 + 32'(k) : 32'h99;
      checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== exp_a || mem_data_o !== exp_d)
        begin errors++; $display("FAIL full_drain%0d: got req=%b addr=%h data=%h want 1 %h %h", k, mem_req_o, mem_addr_o, mem_data_o, exp_a, exp_d); end
      tick();
    end
    mem_ack_i = 1'b0;
    checks++; if (sq_empty_o !== 1'b1) begin errors++; $display("FAIL full_final_empty: got %b want 1", sq_empty_o); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 4; k++) enq(30'h300 + 30'(k), 32'h3000 + 32'(k), 4'b0011);
    commit_n(1);
    flush_i           = 1'b1;
    commit_store_i    = 1'b1;
    enqueue_en_i      = 1'b1;
    enqueue_address_i = 30'h3FF;
    tick();
    idle_inputs();
    mem_ack_i = 1'b1;
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 30'h300 || mem_data_o !== 32'h3000)
      begin errors++; $display("FAIL flush_drain0: got req=%b addr=%h data=%h want 1 300 3000", mem_req_o, mem_addr_o, mem_data_o); end
    tick();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 30'h301 || mem_data_o !== 32'h3001)
      begin errors++; $display("FAIL flush_drain1: got req=%b addr=%h data=%h want 1 301 3001", mem_req_o, mem_addr_o, mem_data_o); end
    tick();
    mem_ack_i = 1'b0;
    checks++; if (sq_empty_o !== 1'b1 || mem_req_o !== 1'b0)
      begin errors++; $display("FAIL flush_empty: got empty=%b req=%b want 1 0", sq_empty_o, mem_req_o); end
  endtask

  task automatic test_conflict();
    do_reset();
    enq(30'h40, 32'h4444, 4'b1100);
    conflict_vld_i = 1'b1; conflict_address_i = 30'h40; conflict_bm_i = 4'b0100;
    tick();
    checks++; if (conflict_o !== 1'b1) begin errors++; $display("FAIL conf_overlap: got %b want 1", conflict_o); end
    conflict_bm_i = 4'b0011;
    tick();
    checks++; if (conflict_o !== 1'b0) begin errors++; $display("FAIL conf_disjoint_bm: got %b want 0", conflict_o); end
    conflict_address_i = 30'h41; conflict_bm_i = 4'b1111;
    tick();
    checks++; if (conflict_o !== 1'b0) begin errors++; $display("FAIL conf_other_addr: got %b want 0", conflict_o); end
    conflict_vld_i = 1'b0; conflict_address_i = 30'h40;
    tick();
    checks++; if (conflict_o !== 1'b0) begin errors++; $display("FAIL conf_not_valid: got %b want 0", conflict_o); end
    conflict_vld_i = 1'b1; conflict_address_i = 30'h50;
    enq(30'h50, 32'h5555, 4'b1111);
    checks++; if (conflict_o !== 1'b0) begin errors++; $display("FAIL conf_same_cycle_enq: got %b want 0", conflict_o); end
    tick();
    conflict_vld_i = 1'b0;
    checks++; if (conflict_o !== 1'b1) begin errors++; $display("FAIL conf_next_cycle: got %b want 1", conflict_o); end
  endtask

  task automatic test_drain_stall();
    do_reset();
    enq(30'h500, 32'hDEAD_BEEF, 4'b1111);
    enq(30'h501, 32'h1234_5678, 4'b1111);
    commit_n(2);
    for (int k = 0; k < 5; k++) begin
      checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 30'h500 || mem_data_o !== 32'hDEAD_BEEF)
        begin errors++; $display("FAIL stall%0d: got req=%b addr=%h data=%h want 1 500 deadbeef", k, mem_req_o, mem_addr_o, mem_data_o); end
      tick();
    end
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 30'h501 || mem_data_o !== 32'h1234_5678)
      begin errors++; $display("FAIL stall_after_ack: got req=%b addr=%h data=%h want 1 501 12345678", mem_req_o, mem_addr_o, mem_data_o); end
    tick();
    checks++; if (mem_addr_o !== 30'h501) begin errors++; $display("FAIL stall_single_pop: got addr=%h want 501", mem_addr_o); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int k = 0; k < 3; k++) enq(30'h600 + 30'(k), 32'h6000 + 32'(k), 4'b1111);
    commit_n(3);
    mem_ack_i = 1'b1;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL midrst_pre_req: got %b want 1", mem_req_o); end
    #2 cpu_resetn_i = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0 || sq_empty_o !== 1'b1)
      begin errors++; $display("FAIL midrst_async: got req=%b empty=%b want 0 1", mem_req_o, sq_empty_o); end
    tick();
    tick();
    mem_ack_i = 1'b0;
    cpu_resetn_i = 1'b1;
    tick();
    checks++; if (mem_req_o !== 1'b0 || sq_empty_o !== 1'b1 || dut.head_q !== 4'b0000)
      begin errors++; $display("FAIL midrst_after: got req=%b empty=%b head=%b want 0 1 0000", mem_req_o, sq_empty_o, dut.head_q); end
  endtask

  initial begin
    idle_inputs();
    cpu_resetn_i = 1'b0;
    test_reset();
    test_basic_flow();
    test_full_backpressure();
    test_flush();
    test_conflict();
    test_drain_stall();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
